// File: rtl/nlfsr_tap_loader.sv
// rtl/nlfsr_tap_loader.sv - Coefficient/seed loader and NLFSR state register feeding the tap-selection network.
module nlfsr_tap_loader #(
  parameter int NUM_OF_TAPS = 15,
  parameter int SIZE        = 32,
  parameter int MAX_IDX     = 19
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     cmd_load,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     run_en,
  input  logic                     feedback,
  output logic [NUM_OF_TAPS*8-1:0] co_buf,
  output logic [SIZE-1:0]          register,
  output logic                     start,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     cfg_err,
  output logic [31:0]              step_cnt
);

  localparam int         SEED_BYTES = SIZE / 8;
  localparam logic [7:0] LAST_COEF  = 8'(NUM_OF_TAPS - 1);
  localparam logic [7:0] LAST_SEED  = 8'(SEED_BYTES - 1);
  localparam logic [7:0] MAX_IDX_B  = 8'(MAX_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_COEF,
    S_LOAD_SEED,
    S_READY,
    S_RUN
  } state_t;

  state_t                   r_state;
  logic [7:0]               r_k;
  logic [NUM_OF_TAPS*8-1:0] r_co_buf;
  logic [SIZE-1:0]          r_register;
  logic                     r_start;
  logic                     r_out_bit;
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_byte_ready;
  logic                     r_cfg_err;
  logic [31:0]              r_step_cnt;

  logic                     w_accept;
  logic                     w_coef_bad;
  logic [31:0]              w_bit_ofs;
  logic [SIZE-1:0]          w_seed;
  logic                     w_seed_zero;

  // cmd_load takes priority over a byte offered on the same edge, so that byte is dropped.
  assign w_accept   = byte_valid && r_byte_ready && !cmd_load;
  assign w_coef_bad = (byte_in == 8'h00) || (byte_in > MAX_IDX_B);
  assign w_bit_ofs  = {24'd0, r_k} << 3;

  // Seed as it will look once the current byte lands; the zero test must include the final byte.
  always_comb begin
    w_seed = r_register;
    w_seed[w_bit_ofs +: 8] = byte_in;
  end

  assign w_seed_zero = (w_seed == '0);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state      <= S_IDLE;
      r_k          <= 8'd0;
      r_co_buf     <= '0;
      r_register   <= '0;
      r_start      <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_ready <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_step_cnt   <= 32'd0;
    end else if (cmd_load) begin
      r_state      <= S_LOAD_COEF;
      r_k          <= 8'd0;
      r_co_buf     <= '0;
      r_cfg_err    <= 1'b0;
      r_start      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b1;
      r_byte_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_start     <= 1'b0;
          r_out_valid <= 1'b0;
        end
        S_LOAD_COEF: begin
          if (w_accept) begin
            r_co_buf[w_bit_ofs +: 8] <= byte_in;
            if (w_coef_bad) r_cfg_err <= 1'b1;
            if (r_k == LAST_COEF) begin
              r_state <= S_LOAD_SEED;
              r_k     <= 8'd0;
            end else begin
              r_k <= r_k + 8'd1;
            end
          end
        end
        S_LOAD_SEED: begin
          if (w_accept) begin
            r_register <= w_seed;
            if (r_k == LAST_SEED) begin
              r_k          <= 8'd0;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
              if (r_cfg_err || w_seed_zero) begin
                r_cfg_err <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                r_state    <= S_READY;
                r_start    <= 1'b1;
                r_step_cnt <= 32'd0;
              end
            end else begin
              r_k <= r_k + 8'd1;
            end
          end
        end
        S_READY: begin
          if (run_en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (run_en) begin
            r_register  <= {feedback, r_register[SIZE-1:1]};
            r_out_bit   <= r_register[0];
            r_out_valid <= 1'b1;
            r_step_cnt  <= r_step_cnt + 32'd1;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_start      <= 1'b0;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
          r_out_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign co_buf     = r_co_buf;
  assign register   = r_register;
  assign start      = r_start;
  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign cfg_err    = r_cfg_err;
  assign step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_nlfsr_tap_loader.sv
// tb/tb_nlfsr_tap_loader.sv - Self-checking bench for nlfsr_tap_loader with a load table and a random run model.
module tb_nlfsr_tap_loader;

  localparam int NT = 15;
  localparam int SZ = 32;

  logic            clk = 1'b0;
  logic            res;
  logic            cmd_load;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic            run_en;
  logic            feedback;
  logic [NT*8-1:0] co_buf;
  logic [SZ-1:0]   register;
  logic            start;
  logic            out_bit;
  logic            out_valid;
  logic            busy;
  logic            cfg_err;
  logic [31:0]     step_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]      m_coef [NT];
  logic [31:0]     m_seed;
  logic [31:0]     exp_reg;
  logic [31:0]     exp_step;
  logic [NT*8-1:0] exp_co;
  bit              ready_ok;

  typedef struct {
    int         bad_pos;
    logic [7:0] bad_val;
    logic [31:0] seed;
    logic       exp_err;
    logic       exp_start;
  } vec_t;

  vec_t vecs [8];

  nlfsr_tap_loader dut (
    .clk       (clk),
    .res       (res),
    .cmd_load  (cmd_load),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .run_en    (run_en),
    .feedback  (feedback),
    .co_buf    (co_buf),
    .register  (register),
    .start     (start),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_co_buf"}, co_buf, 0);
    check({tag, "_register"}, register, 0);
    check({tag, "_step_cnt"}, step_cnt, 0);
    check({tag, "_flags"}, {start, out_bit, out_valid, busy, byte_ready, cfg_err}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        tick();
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    if (byte_ready !== 1'b1 || busy !== 1'b1) ready_ok = 1'b0;
    tick();
    byte_valid = 1'b0;
  endtask

  // Streams m_coef then m_seed (LSB byte first) and checks the loaded result against the load rules.
  task automatic do_load(input bit gaps, input bit send_cmd);
    bit          any_bad;
    bit          err;
    logic [31:0] s;
    any_bad  = 1'b0;
    ready_ok = 1'b1;
    s        = m_seed;
    if (send_cmd) begin
      cmd_load = 1'b1;
      tick();
      cmd_load = 1'b0;
    end
    for (int i = 0; i < NT; i++) begin
      send_byte(m_coef[i], gaps);
      if (m_coef[i] == 8'h00 || m_coef[i] > 8'd19) begin
        any_bad = 1'b1;
        check("cfg_err_after_bad_coef", cfg_err, 1);
      end
    end
    for (int i = 0; i < SZ / 8; i++) send_byte(s[i*8 +: 8], gaps);
    check("ready_busy_during_load", ready_ok, 1);
    for (int i = 0; i < NT; i++) exp_co[i*8 +: 8] = m_coef[i];
    err = any_bad || (m_seed == 32'd0);
    check("load_co_buf", co_buf, exp_co);
    check("load_register", register, m_seed);
    check("load_cfg_err", cfg_err, err);
    check("load_start", start, !err);
    check("load_busy", busy, 0);
    check("load_byte_ready", byte_ready, 0);
    if (!err) exp_step = 32'd0;
    check("load_step_cnt", step_cnt, exp_step);
    exp_reg = m_seed;
  endtask

  task automatic enter_run();
    run_en = 1'b1;
    tick();
    check("enter_run_no_shift", register, exp_reg);
    check("enter_run_out_valid", out_valid, 0);
    check("enter_run_start", start, 1);
  endtask

  task automatic run_cycle(input logic en, input logic fb);
    logic exp_bit;
    run_en   = en;
    feedback = fb;
    exp_bit  = exp_reg[0];
    tick();
    if (en) begin
      exp_reg  = {fb, exp_reg[31:1]};
      exp_step = exp_step + 32'd1;
      check("run_out_valid", out_valid, 1);
      check("run_out_bit", out_bit, exp_bit);
    end else begin
      check("run_out_valid_low", out_valid, 0);
    end
    check("run_register", register, exp_reg);
    check("run_step_cnt", step_cnt, exp_step);
  endtask

  task automatic legal_coefs_seq();
    for (int i = 0; i < NT; i++) m_coef[i] = 8'(i + 1);
  endtask

  task automatic random_load_values();
    for (int i = 0; i < NT; i++) m_coef[i] = 8'($urandom_range(1, 19));
    m_seed = $urandom;
    if (m_seed == 32'd0) m_seed = 32'd1;
  endtask

  initial begin
    logic exp_bits [3];
    exp_bits = '{1'b1, 1'b0, 1'b0};
    vecs[0] = '{3,  8'h14, 32'h80000001, 1'b1, 1'b0};
    vecs[1] = '{-1, 8'h00, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{0,  8'h00, 32'h12345678, 1'b1, 1'b0};
    vecs[3] = '{7,  8'hFF, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{-1, 8'h00, 32'h80000001, 1'b0, 1'b1};
    vecs[5] = '{14, 8'h13, 32'h00000100, 1'b0, 1'b1};
    vecs[6] = '{-1, 8'h00, 32'h01000000, 1'b0, 1'b1};
    vecs[7] = '{5,  8'h01, 32'hA5A5A5A5, 1'b0, 1'b1};

    res = 1'b0; cmd_load = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    run_en = 1'b0; feedback = 1'b0;
    exp_reg = 32'd0; exp_step = 32'd0; exp_co = '0;
    tick();
    tick();
    check_zero_outputs("reset");
    res = 1'b1;

    byte_valid = 1'b1; byte_in = 8'h5A;
    tick();
    byte_valid = 1'b0;
    check("idle_ignores_byte", register, 0);
    check("idle_byte_ready", byte_ready, 0);

    // Normal load followed by a 3-step run with feedback tied high.
    legal_coefs_seq();
    m_seed = 32'h80000001;
    do_load(1'b0, 1'b1);
    check("co_buf_first_tap", co_buf[7:0], 8'h01);
    check("co_buf_last_tap", co_buf[119:112], 8'h0F);
    enter_run();
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b1);
      check("fixed_out_bit_seq", out_bit, exp_bits[i]);
    end
    check("run3_register", register, 32'hF0000000);
    check("run3_step_cnt", step_cnt, 32'd3);
    run_cycle(1'b0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      legal_coefs_seq();
      if (vecs[v].bad_pos >= 0) m_coef[vecs[v].bad_pos] = vecs[v].bad_val;
      m_seed = vecs[v].seed;
      do_load(1'b0, 1'b1);
      check("tbl_cfg_err", cfg_err, vecs[v].exp_err);
      check("tbl_start", start, vecs[v].exp_start);
    end

    random_load_values();
    do_load(1'b1, 1'b1);
    enter_run();
    for (int c = 0; c < 300; c++) run_cycle(1'($urandom_range(0, 9) < 7), 1'($urandom));

    // Abort during RUN at step 5, with a byte offered on the same edge.
    random_load_values();
    do_load(1'b1, 1'b1);
    enter_run();
    for (int c = 0; c < 5; c++) run_cycle(1'b1, 1'($urandom));
    cmd_load = 1'b1; byte_valid = 1'b1; byte_in = 8'h55; run_en = 1'b1; feedback = 1'b1;
    tick();
    cmd_load = 1'b0; byte_valid = 1'b0; run_en = 1'b0;
    check("abort_busy", busy, 1);
    check("abort_start", start, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_byte_ready", byte_ready, 1);
    check("abort_co_buf", co_buf, 0);
    check("abort_cfg_err", cfg_err, 0);
    check("abort_step_cnt", step_cnt, 32'd5);
    check("abort_register_hold", register, exp_reg);
    random_load_values();
    do_load(1'b1, 1'b0);

    // Asynchronous reset in the middle of the seed bytes.
    legal_coefs_seq();
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int i = 0; i < NT; i++) send_byte(m_coef[i], 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    #2;
    res = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    tick();
    res = 1'b1;
    byte_valid = 1'b1; byte_in = 8'hAA;
    tick();
    byte_valid = 1'b0;
    check("post_reset_idle_register", register, 0);
    check("post_reset_byte_ready", byte_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
